// File: rtl/myfpga_config_loader.sv
// Serial configuration loader: framed bitstream -> per-chain config registers.
// Ports: i_ConfigClock/i_Reset, i_ConfigActive/i_ConfigData in; o_Config,
// o_LoadedMask, o_FrameOk, o_FrameErr, o_Error, o_Busy, o_Done out.
module myfpga_config_loader #(
  parameter int NUM_CHAINS   = 4,
  parameter int CHAIN_LENGTH = 32,
  parameter int SEL_W        = 8
) (
  input  logic                               i_ConfigClock,
  input  logic                               i_Reset,
  input  logic                               i_ConfigActive,
  input  logic                               i_ConfigData,
  output logic [NUM_CHAINS*CHAIN_LENGTH-1:0] o_Config,
  output logic [NUM_CHAINS-1:0]              o_LoadedMask,
  output logic                               o_FrameOk,
  output logic                               o_FrameErr,
  output logic                               o_Error,
  output logic                               o_Busy,
  output logic                               o_Done
);

  localparam int MAXL = (SEL_W > CHAIN_LENGTH) ? SEL_W : CHAIN_LENGTH;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CHECK
  } state_t;

  state_t                               state_q, state_d;
  logic [CW-1:0]                        cnt_q;
  logic [SEL_W-1:0]                     hdr_q;
  logic [CHAIN_LENGTH-1:0]              stg_q;
  logic                                 par_q;
  logic [NUM_CHAINS*CHAIN_LENGTH-1:0]   cfg_q;
  logic [NUM_CHAINS-1:0]                mask_q;
  logic                                 err_q;
  logic                                 done_q;
  logic                                 ok_q;
  logic                                 ferr_q;

  logic act;
  logic din;
  logic hdr_last;
  logic pay_last;
  logic idx_ok;
  logic busy;
  logic start;
  logic in_hdr;
  logic in_pay;
  logic chk;
  logic abort_f;
  logic clean_end;
  logic frame_ok;
  logic frame_bad;

  assign act      = i_ConfigActive;
  assign din      = i_ConfigData;
  assign hdr_last = (cnt_q == CW'(SEL_W - 1));
  assign pay_last = (cnt_q == CW'(CHAIN_LENGTH - 1));
  // Extra MSB so NUM_CHAINS == 2**SEL_W does not wrap to zero.
  assign idx_ok   = ({1'b0, hdr_q} < (SEL_W + 1)'(NUM_CHAINS));

  always_ff @(posedge i_ConfigClock or posedge i_Reset) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // The session-start edge already consumes header bit 0.
        if (act) state_d = hdr_last ? PAYLOAD : HEADER;
      end
      HEADER: begin
        if (!act)          state_d = IDLE;
        else if (hdr_last) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (!act)          state_d = IDLE;
        else if (pay_last) state_d = CHECK;
      end
      CHECK: begin
        state_d = act ? HEADER : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    in_hdr    = 1'b0;
    in_pay    = 1'b0;
    chk       = 1'b0;
    clean_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_hdr = act;
      end
      HEADER: begin
        busy      = (cnt_q != '0);
        in_hdr    = act;
        clean_end = !act && (cnt_q == '0);
      end
      PAYLOAD: begin
        busy   = 1'b1;
        in_pay = act;
      end
      CHECK: begin
        busy = 1'b1;
        chk  = act;
      end
      default: ;
    endcase
    start     = (state_q == IDLE) && act;
    abort_f   = busy && !act;
    frame_ok  = chk && !(par_q ^ din) && idx_ok;
    frame_bad = chk && !frame_ok;
  end

  always_ff @(posedge i_ConfigClock or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q  <= '0;
      hdr_q  <= '0;
      stg_q  <= '0;
      par_q  <= 1'b0;
      cfg_q  <= '0;
      mask_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ok_q   <= frame_ok;
      ferr_q <= frame_bad || abort_f;
      if (start) begin
        err_q  <= 1'b0;
        mask_q <= '0;
        done_q <= 1'b0;
      end
      if (in_hdr) begin
        hdr_q <= SEL_W'({hdr_q, din});
        // Count zero in HEADER/IDLE marks the first bit of a new frame.
        par_q <= (cnt_q == '0) ? din : (par_q ^ din);
        cnt_q <= hdr_last ? '0 : cnt_q + CW'(1);
      end
      if (in_pay) begin
        stg_q <= CHAIN_LENGTH'({stg_q, din});
        par_q <= par_q ^ din;
        cnt_q <= pay_last ? '0 : cnt_q + CW'(1);
      end
      if (frame_ok) begin
        for (int k = 0; k < NUM_CHAINS; k++) begin
          if (hdr_q == SEL_W'(k)) begin
            cfg_q[k*CHAIN_LENGTH +: CHAIN_LENGTH] <= stg_q;
            mask_q[k] <= 1'b1;
          end
        end
      end
      if (frame_bad || abort_f) err_q <= 1'b1;
      if (abort_f) begin
        stg_q <= '0;
        cnt_q <= '0;
      end
      if (clean_end) done_q <= (&mask_q) && !err_q;
    end
  end

  assign o_Config     = cfg_q;
  assign o_LoadedMask = mask_q;
  assign o_FrameOk    = ok_q;
  assign o_FrameErr   = ferr_q;
  assign o_Error      = err_q;
  assign o_Busy       = busy;
  assign o_Done       = done_q;

endmodule

// File: tb/tb_myfpga_config_loader.sv
// Bench for myfpga_config_loader: directed frames, scoreboard of pulses.
// Expected pulses are queued by the driver and checked by a monitor.
module tb_myfpga_config_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         act;
  logic         dat;
  logic [127:0] o_cfg;
  logic [3:0]   o_mask;
  logic         o_ok;
  logic         o_ferr;
  logic         o_err;
  logic         o_busy;
  logic         o_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    bit           ok;
    logic [127:0] cfg;
    logic [3:0]   mask;
    bit           err;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  logic [127:0] m_cfg  = '0;
  logic [3:0]   m_mask = '0;
  bit           m_err  = 1'b0;

  myfpga_config_loader dut (
    .i_ConfigClock  (clk),
    .i_Reset        (rst),
    .i_ConfigActive (act),
    .i_ConfigData   (dat),
    .o_Config       (o_cfg),
    .o_LoadedMask   (o_mask),
    .o_FrameOk      (o_ok),
    .o_FrameErr     (o_ferr),
    .o_Error        (o_err),
    .o_Busy         (o_busy),
    .o_Done         (o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [127:0] a,
                     input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (o_ok && o_ferr) begin
      tests++;
      fails++;
      $display("FAIL both_pulses: got ok=1 err=1 expected one");
    end else if (o_ok || o_ferr) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got ok=%0b err=%0b expected none",
                 o_ok, o_ferr);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind_ok", o_ok, e.ok);
        chk("pulse_cfg", o_cfg, e.cfg);
        chk("pulse_mask", o_mask, e.mask);
        chk("pulse_err", o_err, e.err);
        if (e.cyc >= 0) chk("ok_latency", cyc, e.cyc);
      end
    end
  end

  task automatic send_bit(input logic b);
    act = 1'b1;
    dat = b;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session();
    m_mask = '0;
    m_err  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] idx,
                            input logic [31:0] pay,
                            input bit flip,
                            input bit timed,
                            input int nbits,
                            input bit want);
    logic [40:0] f;
    exp_t        e;
    bit          good;
    f = {idx, pay, (^idx) ^ (^pay) ^ flip};
    good = !flip && (idx < 8'd4) && (nbits == 41);
    if (want) begin
      if (good) begin
        m_cfg[int'(idx)*32 +: 32] = pay;
        m_mask[idx[1:0]] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      e.ok   = good;
      e.cfg  = m_cfg;
      e.mask = m_mask;
      e.err  = m_err;
      e.cyc  = timed ? cyc + 41 : -1;
      sb.push_back(e);
    end
    for (int i = 40; i > 40 - nbits; i--) send_bit(f[i]);
  endtask

  task automatic end_session(input bit exp_done);
    act = 1'b0;
    dat = 1'b0;
    @(posedge clk);
    #1;
    chk("end_busy", o_busy, 1'b0);
    chk("end_done", o_done, exp_done);
    chk("end_error", o_err, m_err);
    chk("end_mask", o_mask, m_mask);
    chk("end_cfg", o_cfg, m_cfg);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cfg"}, o_cfg, '0);
    chk({tag, "_mask"}, o_mask, '0);
    chk({tag, "_ok"}, o_ok, 1'b0);
    chk({tag, "_ferr"}, o_ferr, 1'b0);
    chk({tag, "_err"}, o_err, 1'b0);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    act = 1'b0;
    dat = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single timed frame to chain 2.
    begin_session();
    send_frame(8'd2, 32'hDEADBEEF, 1'b0, 1'b1, 41, 1'b1);
    end_session(1'b0);

    // All chains back to back: clean session with done.
    begin_session();
    send_frame(8'd0, 32'h11111111, 1'b0, 1'b0, 41, 1'b1);
    send_frame(8'd1, 32'h22222222, 1'b0, 1'b0, 41, 1'b1);
    send_frame(8'd2, 32'h33333333, 1'b0, 1'b0, 41, 1'b1);
    send_frame(8'd3, 32'h44444444, 1'b0, 1'b0, 41, 1'b1);
    end_session(1'b1);

    // Bad parity on chain 1.
    begin_session();
    send_frame(8'd1, 32'h12345678, 1'b1, 1'b0, 41, 1'b1);
    end_session(1'b0);

    // Out-of-range chain index.
    begin_session();
    send_frame(8'd7, 32'h0F0F0F0F, 1'b0, 1'b0, 41, 1'b1);
    end_session(1'b0);

    // Abort after 20 bits.
    begin_session();
    send_frame(8'd0, 32'hAAAA5555, 1'b0, 1'b0, 20, 1'b1);
    end_session(1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-payload, then a normal load.
    begin_session();
    send_frame(8'd3, 32'h5A5A5A5A, 1'b0, 1'b0, 20, 1'b0);
    #3;
    rst = 1'b1;
    act = 1'b0;
    dat = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m_cfg  = '0;
    m_mask = '0;
    m_err  = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    begin_session();
    send_frame(8'd3, 32'hCAFEF00D, 1'b0, 1'b0, 41, 1'b1);
    end_session(1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_pulses", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/myfpga_config_loader.md
MYFPGA_CONFIG_LOADER -- requirements
Module: myfpga_config_loader

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 4, the number of independent configuration chains.
REQ-002 SHALL have parameter CHAIN_LENGTH, default 32, the bits per chain.
REQ-003 SHALL have parameter SEL_W, default 8, the header chain-index width; NUM_CHAINS <= 2**SEL_W.
REQ-004 SHALL have one clock and an asynchronous, active-high reset:
- i_ConfigClock  input  1  sole clock; all logic on rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have the following ports:
- i_ConfigActive  input  1  session enable; each edge with it high consumes one bit.
- i_ConfigData  input  1  serial bitstream bit.
- o_Config  output  NUM_CHAINS*CHAIN_LENGTH  committed config; chain k at [k*CHAIN_LENGTH +: CHAIN_LENGTH].
- o_LoadedMask  output  NUM_CHAINS  bit k set once chain k is committed in the current session.
- o_FrameOk  output  1  one-cycle pulse per committed frame.
- o_FrameErr  output  1  one-cycle pulse per rejected or aborted frame.
- o_Error  output  1  sticky session error.
- o_Busy  output  1  high while a frame is partially received.
- o_Done  output  1  session completed cleanly.

Function
REQ-006 Frame format SHALL be SEL_W header bits (chain index, MSB first), then CHAIN_LENGTH payload bits (MSB first), then 1 even-parity check bit: SEL_W+CHAIN_LENGTH+1 bits total (41 at defaults).
REQ-007 The FSM SHALL have states IDLE, HEADER, PAYLOAD and CHECK, with a bit counter sized for max(SEL_W, CHAIN_LENGTH).
REQ-008 IDLE->HEADER SHALL occur on the first edge with i_ConfigActive=1; that edge consumes header bit 0, clears o_Error, o_LoadedMask and o_Done, and holds o_Config.
REQ-009 HEADER->PAYLOAD SHALL occur after SEL_W bits, and PAYLOAD->CHECK after CHAIN_LENGTH bits.
REQ-010 The CHECK bit edge SHALL return the FSM to HEADER, so back-to-back frames need no gap cycles.
REQ-011 Payload SHALL shift into a staging register; o_Config SHALL NOT change before the check bit.
REQ-012 On the check-bit edge, a frame SHALL be valid iff the XOR of all header, payload and check bits is 0 and index < NUM_CHAINS.
REQ-013 A valid frame SHALL, on that same edge, write staging to chain[index], set o_LoadedMask[index], and pulse o_FrameOk the following cycle.
REQ-014 An invalid frame SHALL leave o_Config and o_LoadedMask unchanged, set o_Error, and pulse o_FrameErr.
REQ-015 Reloading an already-loaded chain SHALL overwrite it; this is not an error.
REQ-016 o_Busy SHALL be 1 when state is PAYLOAD or CHECK, or state is HEADER with bit count > 0; otherwise 0.
REQ-017 If i_ConfigActive is sampled 0 in HEADER with count 0, the FSM SHALL go to IDLE (clean end).
REQ-018 On a clean end, o_Done SHALL be set iff o_LoadedMask is all ones and o_Error=0.
REQ-019 If i_ConfigActive is sampled 0 while o_Busy=1, the FSM SHALL abort: discard staging, no commit, set o_Error, pulse o_FrameErr, go to IDLE, and leave o_Done at 0.
REQ-020 o_Done SHALL hold until reset or the next session start.
REQ-021 o_FrameOk and o_FrameErr SHALL never both be 1 in the same cycle.

Reset
REQ-022 While i_Reset=1, all outputs SHALL be 0 (including o_Config), the FSM SHALL be IDLE, and the counter and staging register SHALL be 0, regardless of clock.
REQ-023 Reset asserted mid-frame SHALL discard the frame without any pulse.
REQ-024 After reset release, the first edge with i_ConfigActive=1 SHALL start a header per REQ-008.

Verification
REQ-025 The bench SHALL cover these directed scenarios (defaults):
- Frame index=2, payload 0xDEADBEEF, correct parity -> o_Config[95:64]=0xDEADBEEF, o_LoadedMask=0100, one o_FrameOk pulse 41 cycles after start.
- Four valid back-to-back frames for chains 0..3, then i_ConfigActive=0 -> o_LoadedMask=1111, o_Done=1, o_Error=0.
- Frame index=1 with parity bit flipped -> o_Config unchanged, o_FrameErr pulse, o_Error=1; session end gives o_Done=0.
- Frame index=7 (>=NUM_CHAINS), correct parity -> rejected, o_FrameErr pulse, o_Error=1.
- i_ConfigActive dropped after 20 bits -> no commit, o_FrameErr pulse, o_Busy=0, state IDLE, o_Done=0.
- i_Reset asserted asynchronously mid-payload -> all outputs 0 immediately; a new session then loads normally.
